clk_div_count_calc: RTL and testbench

CLK_DIV_COUNT_CALC -- requirements
Module: clk_div_count_calc

---
 rtl/clk_div_count_calc.sv | 198 +++++++++++++++++++
 tb/tb_clk_div_count_calc.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/clk_div_count_calc.sv
// Derives an SD clock divider count from a CSD TRAN_SPEED byte (or INIT_RATE) by
// serial restoring division of CLK_FREQ. Optional macro CLK_DIV_ROUND_UP_EN rounds the quotient up.
module clk_div_count_calc #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int DIV_W      = 32,
  parameter int COUNT_W    = 16,
  parameter int RATE_SHIFT = 2,
  parameter int INIT_RATE  = 100_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               init_mode,
  input  logic [7:0]         tran_speed,
  output logic               busy,
  output logic               ok,
  output logic               err,
  output logic               sat,
  output logic               clk_div_reset,
  output logic [COUNT_W-1:0] count,
  output logic [1:0]         dbg_state
);

  localparam int ITER_W = (DIV_W > 1) ? $clog2(DIV_W) : 1;

  typedef enum logic [1:0] {IDLE, RATE, DIV, DONE} state_t;

  // Handshake: start is a level request taken only when the FSM sits in IDLE;
  // ok/err are single-cycle completion pulses, and busy covers every non-IDLE state.
  state_t              state_q, state_d;
  logic                init_q, init_d;
  logic [6:0]          ts_q, ts_d;
  logic [DIV_W-1:0]    rate_q, rate_d;
  logic [DIV_W-1:0]    rem_q, rem_d;
  logic [DIV_W-1:0]    quo_q, quo_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic                err_pend_q, err_pend_d;
  logic                ok_q, ok_d;
  logic                err_q, err_d;
  logic                sat_q, sat_d;
  logic                cdr_q, cdr_d;
  logic [COUNT_W-1:0]  count_q, count_d;

  logic [6:0]          mant;
  logic [DIV_W-1:0]    unit;
  logic                code_bad;
  logic [DIV_W-1:0]    rate_calc;
  logic [DIV_W:0]      rem_shift;
  logic [DIV_W:0]      q_ext;

  always_comb begin
    mant = 7'd0;
    case (ts_q[6:3])
      4'h1: mant = 7'd10;
      4'h2: mant = 7'd12;
      4'h3: mant = 7'd13;
      4'h4: mant = 7'd15;
      4'h5: mant = 7'd20;
      4'h6: mant = 7'd25;
      4'h7: mant = 7'd30;
      4'h8: mant = 7'd35;
      4'h9: mant = 7'd40;
      4'hA: mant = 7'd45;
      4'hB: mant = 7'd50;
      4'hC: mant = 7'd55;
      4'hD: mant = 7'd60;
      4'hE: mant = 7'd70;
      4'hF: mant = 7'd80;
      default: mant = 7'd0;
    endcase
    unit = '0;
    case (ts_q[2:0])
      3'd0: unit = DIV_W'(10_000);
      3'd1: unit = DIV_W'(100_000);
      3'd2: unit = DIV_W'(1_000_000);
      3'd3: unit = DIV_W'(10_000_000);
      default: unit = '0;
    endcase
    code_bad = (ts_q[6:3] == 4'h0) || ts_q[2];
    rate_calc = init_q ? DIV_W'(INIT_RATE) : ((DIV_W'(mant) * unit) >> RATE_SHIFT);
  end

  always_comb begin
    // The next dividend bit is the MSB of quo_q, which starts as CLK_FREQ and fills with quotient bits.
    rem_shift = {rem_q, quo_q[DIV_W-1]};
`ifdef CLK_DIV_ROUND_UP_EN
    q_ext = {1'b0, quo_q} + (DIV_W+1)'(rem_q != '0);
`else
    q_ext = {1'b0, quo_q};
`endif
  end

  always_comb begin
    state_d    = state_q;
    init_d     = init_q;
    ts_d       = ts_q;
    rate_d     = rate_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    iter_d     = iter_q;
    err_pend_d = err_pend_q;
    ok_d       = 1'b0;
    err_d      = 1'b0;
    sat_d      = sat_q;
    cdr_d      = ok_q;
    count_d    = count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          init_d  = init_mode;
          ts_d    = tran_speed[6:0];
          state_d = RATE;
        end
      end
      RATE: begin
        rate_d = rate_calc;
        rem_d  = '0;
        quo_d  = DIV_W'(CLK_FREQ);
        iter_d = '0;
        if ((!init_q && code_bad) || (rate_calc == '0)) begin
          err_pend_d = 1'b1;
          state_d    = DONE;
        end else begin
          err_pend_d = 1'b0;
          state_d    = DIV;
        end
      end
      DIV: begin
        if (rem_shift >= {1'b0, rate_q}) begin
          rem_d = DIV_W'(rem_shift - {1'b0, rate_q});
          quo_d = {quo_q[DIV_W-2:0], 1'b1};
        end else begin
          rem_d = rem_shift[DIV_W-1:0];
          quo_d = {quo_q[DIV_W-2:0], 1'b0};
        end
        iter_d = iter_q + 1'b1;
        if (iter_q == ITER_W'(DIV_W-1)) state_d = DONE;
      end
      DONE: begin
        if (err_pend_q) begin
          err_d = 1'b1;
        end else begin
          ok_d = 1'b1;
          if (|q_ext[DIV_W:COUNT_W]) begin
            sat_d   = 1'b1;
            count_d = '1;
          end else begin
            sat_d   = 1'b0;
            count_d = q_ext[COUNT_W-1:0];
          end
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      init_q     <= 1'b0;
      ts_q       <= '0;
      rate_q     <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      iter_q     <= '0;
      err_pend_q <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      sat_q      <= 1'b0;
      cdr_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      init_q     <= init_d;
      ts_q       <= ts_d;
      rate_q     <= rate_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      iter_q     <= iter_d;
      err_pend_q <= err_pend_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      sat_q      <= sat_d;
      cdr_q      <= cdr_d;
      count_q    <= count_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign ok            = ok_q;
  assign err           = err_q;
  assign sat           = sat_q;
  assign clk_div_reset = cdr_q;
  assign count         = count_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_clk_div_count_calc.sv
// Randomized bench for clk_div_count_calc: a 16-bit and an 8-bit count instance share
// stimulus and are checked against an arithmetic model of the rate/division rules.
module tb_clk_div_count_calc;

  localparam longint CLK_FREQ   = 50_000_000;
  localparam int     RATE_SHIFT = 2;
  localparam longint INIT_RATE  = 100_000;

  logic        clk = 1'b0;
  logic        reset, start, init_mode;
  logic [7:0]  tran_speed;
  logic        busy, ok, err, sat, cdr;
  logic [15:0] count;
  logic [1:0]  dbg_state;
  logic        busy8, ok8, err8, sat8, cdr8;
  logic [7:0]  count8;
  logic [1:0]  dbg_state8;

  int total = 0;
  int bad   = 0;
  logic [25:0] exp_q[$];        // {sat8, count8, sat16, count16}
  logic [15:0] e_cnt16 = '0;
  logic        e_sat16 = 1'b0;
  logic [7:0]  e_cnt8  = '0;
  logic        e_sat8  = 1'b0;

  clk_div_count_calc u_dut (
    .clk(clk), .reset(reset), .start(start), .init_mode(init_mode), .tran_speed(tran_speed),
    .busy(busy), .ok(ok), .err(err), .sat(sat), .clk_div_reset(cdr), .count(count),
    .dbg_state(dbg_state)
  );

  clk_div_count_calc #(.COUNT_W(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start), .init_mode(init_mode), .tran_speed(tran_speed),
    .busy(busy8), .ok(ok8), .err(err8), .sat(sat8), .clk_div_reset(cdr8), .count(count8),
    .dbg_state(dbg_state8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: rate from the TRAN_SPEED tables, then integer division of CLK_FREQ.
  function automatic void model(input bit im, input logic [7:0] ts, output bit e, output longint q);
    longint mant_tab[16] = '{0, 10, 12, 13, 15, 20, 25, 30, 35, 40, 45, 50, 55, 60, 70, 80};
    longint unit_tab[4]  = '{10_000, 100_000, 1_000_000, 10_000_000};
    int mc;
    int uc;
    longint rate;
    mc = int'(ts[6:3]);
    uc = int'(ts[2:0]);
    e  = 1'b0;
    q  = 0;
    if (im) begin
      rate = INIT_RATE;
    end else if (mc == 0 || uc > 3) begin
      e = 1'b1;
      return;
    end else begin
      rate = ((mant_tab[mc] * unit_tab[uc]) & 64'hFFFF_FFFF) >> RATE_SHIFT;
    end
    if (rate == 0) begin
      e = 1'b1;
      return;
    end
    q = CLK_FREQ / rate;
`ifdef CLK_DIV_ROUND_UP_EN
    if (CLK_FREQ % rate != 0) q = q + 1;
`endif
  endfunction

  task automatic check_counts(input string tag);
    chk({tag, "_count16"}, 64'(count),  64'(e_cnt16));
    chk({tag, "_sat16"},   64'(sat),    64'(e_sat16));
    chk({tag, "_count8"},  64'(count8), 64'(e_cnt8));
    chk({tag, "_sat8"},    64'(sat8),   64'(e_sat8));
  endtask

  task automatic run(input bit im, input logic [7:0] ts, input bit hold);
    bit     e;
    longint q;
    int     ev;
    logic [25:0] w;
    model(im, ts, e, q);
    if (!e) exp_q.push_back({(q > 255) ? 1'b1 : 1'b0, (q > 255) ? 8'hFF : 8'(q),
                             (q > 65535) ? 1'b1 : 1'b0, (q > 65535) ? 16'hFFFF : 16'(q)});
    @(negedge clk);
    start = 1'b1; init_mode = im; tran_speed = ts;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    // Inputs wander while busy; only the latched values may matter.
    tran_speed = 8'($urandom);
    init_mode  = 1'($urandom_range(0, 1));
    ev = e ? 2 : 34;
    for (int k = 1; k <= ev + 2; k++) begin
      @(posedge clk); #1;
      chk("ok",  64'(ok),  64'(!e && k == ev));
      chk("err", 64'(err), 64'(e && k == ev));
      chk("cdr", 64'(cdr), 64'(!e && k == ev + 1));
      chk("ok8", 64'(ok8), 64'(!e && k == ev));
      if (k != ev) chk("busy", 64'(busy), 64'(k < ev));
      if (k == ev) begin
        if (!e) begin
          if (exp_q.size() == 0) begin
            chk("exp_q_empty", 64'(1), 64'(0));
          end else begin
            w = exp_q.pop_front();
            {e_sat8, e_cnt8, e_sat16, e_cnt16} = w;
          end
        end
        check_counts(e ? "err_hold" : "result");
        start = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; init_mode = 1'b0; tran_speed = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ok",   64'(ok),   64'(0));
    chk("rst_err",  64'(err),  64'(0));
    chk("rst_cdr",  64'(cdr),  64'(0));
    check_counts("rst");
    @(negedge clk); reset = 1'b0;

    // Directed points from the rate table and boundaries.
    run(1'b0, 8'h32, 1'b0);
    run(1'b0, 8'h1A, 1'b0);
    run(1'b0, 8'h00, 1'b0);
    run(1'b0, 8'h2C, 1'b1);
    run(1'b0, 8'h08, 1'b0);
    run(1'b1, 8'h55, 1'b1);
    run(1'b0, 8'hFB, 1'b1);

    // Reset in the middle of a division.
    @(negedge clk);
    start = 1'b1; init_mode = 1'b0; tran_speed = 8'h32;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    e_cnt16 = '0; e_sat16 = 1'b0; e_cnt8 = '0; e_sat8 = 1'b0;
    exp_q.delete();
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_ok",   64'(ok),   64'(0));
    chk("midrst_err",  64'(err),  64'(0));
    chk("midrst_cdr",  64'(cdr),  64'(0));
    check_counts("midrst");
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      chk("midrst_no_ok",  64'(ok | err | cdr), 64'(0));
    end

    // Reset wins over a simultaneous start.
    @(negedge clk);
    reset = 1'b1; start = 1'b1; tran_speed = 8'h32;
    @(posedge clk); #1;
    chk("rst_vs_start", 64'(busy), 64'(0));
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("rst_vs_start_idle", 64'(busy), 64'(0));

    for (int i = 0; i < 15; i++) begin
      run(($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
